// File: rtl/subtractor_32bit_pipe.sv
// Pipelined two's-complement subtractor: one SLICE-bit slice per stage, borrow rippling
// stage to stage, with valid/ready handshakes and a single global advance.
module subtractor_32bit_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SLICE = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf
);

  localparam int unsigned NSTAGE = WIDTH / SLICE;

  if ((WIDTH % SLICE) != 0 || NSTAGE == 0) begin : g_bad_cfg
    $error("subtractor_32bit_pipe: WIDTH must be a non-zero multiple of SLICE");
  end

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  for (genvar g = 0; g < NSTAGE; g++) begin : stg
    localparam int unsigned DW = (g + 1) * SLICE;
    localparam int unsigned IW = WIDTH - g * SLICE;
    localparam int unsigned RW = WIDTH - DW;

    logic          v_in;
    logic          bin;
    logic [IW-1:0] opa;
    logic [IW-1:0] opb;
    logic [SLICE:0] sub;
    logic [DW-1:0] d_next;
    logic          v_q;
    logic          bo_q;
    logic [DW-1:0] d_q;

    // Remaining operand slices shift down each stage, so the operand MSBs
    // ride along in the top of opa/opb until the last stage needs them.
    if (g == 0) begin : g_head
      assign v_in   = in_valid;
      assign bin    = 1'b0;
      assign opa    = a;
      assign opb    = b;
      assign d_next = sub[SLICE-1:0];
    end else begin : g_body
      assign v_in   = stg[g-1].v_q;
      assign bin    = stg[g-1].bo_q;
      assign opa    = stg[g-1].g_rem.ar_q;
      assign opb    = stg[g-1].g_rem.br_q;
      assign d_next = {sub[SLICE-1:0], stg[g-1].d_q};
    end

    assign sub = {1'b0, opa[SLICE-1:0]} - {1'b0, opb[SLICE-1:0]} - {{SLICE{1'b0}}, bin};

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q  <= 1'b0;
        bo_q <= 1'b0;
        d_q  <= '0;
      end else if (advance) begin
        v_q  <= v_in;
        bo_q <= sub[SLICE];
        d_q  <= d_next;
      end
    end

    if (RW > 0) begin : g_rem
      logic [RW-1:0] ar_q;
      logic [RW-1:0] br_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ar_q <= '0;
          br_q <= '0;
        end else if (advance) begin
          ar_q <= opa[IW-1:SLICE];
          br_q <= opb[IW-1:SLICE];
        end
      end
    end else begin : g_last
      logic ovf_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ovf_q <= 1'b0;
        end else if (advance) begin
          ovf_q <= (opa[SLICE-1] != opb[SLICE-1]) && (sub[SLICE-1] != opa[SLICE-1]);
        end
      end
    end
  end

  assign out_valid  = stg[NSTAGE-1].v_q;
  assign diff       = stg[NSTAGE-1].d_q;
  assign borrow_out = stg[NSTAGE-1].bo_q;
  assign ovf        = stg[NSTAGE-1].g_last.ovf_q;

endmodule
